// File: rtl/inpdt_mac_acc.sv
// Inner-product accumulator: four zero-point-corrected 8-bit MAC lanes per beat,
// summed over NUM_BEATS beats into a wrapping 32-bit signed result that is held
// in inpdt_R_reg and offered downstream with a valid/ready handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; inpdt_R_reg keeps the last completed sum
// S_ACC  | accepting beats (in_ready=1), accumulating lane sums
// S_DONE | sum complete (acc_valid=1), waiting for acc_ready
module inpdt_mac_acc #(
    parameter logic [7:0] ZERO_DATA = 8'd128,
    parameter logic [7:0] ZERO_W    = 8'd128,
    parameter int         NUM_BEATS = 32,
    parameter int         CNT_W     = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [31:0] w_in,
    output logic        acc_valid,
    input  logic        acc_ready,
    output logic [31:0] inpdt_R_reg,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_q, res_d;

    logic signed [8:0]  dx [4];
    logic signed [8:0]  dw [4];
    logic signed [17:0] prod [4];
    logic signed [19:0] lane_sum;
    logic [31:0]        acc_next;

    // Zero-point removal, per-lane products and their sign-extended sum.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < 4; i++) begin
            dx[i]   = $signed({1'b0, data_in[8*i +: 8]}) - $signed({1'b0, ZERO_DATA});
            dw[i]   = $signed({1'b0, w_in[8*i +: 8]})    - $signed({1'b0, ZERO_W});
            prod[i] = 18'(dx[i]) * 18'(dw[i]);
            lane_sum = lane_sum + 20'(prod[i]);
        end
        acc_next = acc_q + 32'(lane_sum);
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        acc_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        res_d   = acc_next;
                    end
                end
            end
            S_DONE: begin
                acc_valid = 1'b1;
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign inpdt_R_reg = res_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_inpdt_mac_acc.sv
// Directed bench for inpdt_mac_acc: expected sums are computed from the driven
// beats, queued, and compared when the result handshake completes.
module tb_inpdt_mac_acc;

    localparam int NB = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        in_valid;
    logic        acc_ready;
    logic [31:0] data_in;
    logic [31:0] w_in;
    logic        in_ready;
    logic        acc_valid;
    logic        busy;
    logic [31:0] inpdt_R_reg;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    inpdt_mac_acc #(
        .ZERO_DATA(8'd128), .ZERO_W(8'd128), .NUM_BEATS(NB), .CNT_W(10)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .w_in(w_in),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .inpdt_R_reg(inpdt_R_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_beat(input logic [31:0] d, input logic [31:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += (int'(d[8*i +: 8]) - 128) * (int'(w[8*i +: 8]) - 128);
        return s;
    endfunction

    task automatic set_pattern(input int mode);
        case (mode)
            0: begin data_in = 32'h8080_8080; w_in = 32'h8080_8080; end
            1: begin data_in = 32'h0000_0000; w_in = 32'h0000_0000; end
            2: begin data_in = 32'hFFFF_FFFF; w_in = 32'h0000_0000; end
            default: begin data_in = $urandom; w_in = $urandom; end
        endcase
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives beats until nbeats are accepted; returns the cycles spent.
    task automatic run_beats(input int mode, input bit gaps, input bit start_mid,
                             input int nbeats, input bit push, output int cyc);
        int n;
        int sum;
        n = 0; sum = 0; cyc = 0;
        while (n < nbeats && cyc < 1000) begin
            set_pattern(mode);
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            start    = (start_mid && cyc == 5);
            chk("acc_in_ready", 32'(in_ready), 32'd1);
            chk("acc_no_valid", 32'(acc_valid), 32'd0);
            if (in_valid && in_ready) begin
                sum += model_beat(data_in, w_in);
                n++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("beats_accepted", 32'(n), 32'(nbeats));
        if (push) exp_q.push_back(sum);
    endtask

    // Waits for acc_valid, holds acc_ready low for delay cycles, then handshakes.
    task automatic finish_result(input int delay, input bit start_in_done);
        int n;
        int expv;
        n = 0;
        while (!acc_valid && n < 200) begin
            tick();
            n++;
        end
        chk("acc_valid_seen", 32'(acc_valid), 32'd1);
        chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        for (int i = 0; i < delay; i++) begin
            acc_ready = 1'b0;
            start     = (start_in_done && i == 2);
            chk("done_valid_hold", 32'(acc_valid), 32'd1);
            chk("done_no_in_ready", 32'(in_ready), 32'd0);
            chk("done_result_hold", inpdt_R_reg, 32'(expv));
            tick();
        end
        acc_ready = 1'b1;
        start     = start_in_done;
        chk("result", inpdt_R_reg, 32'(expv));
        tick();
        acc_ready = 1'b0;
        start     = 1'b0;
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid", 32'(acc_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd0);
        chk("idle_result_kept", inpdt_R_reg, 32'(expv));
    endtask

    initial begin
        int cyc;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; acc_ready = 1'b0;
        data_in = '0; w_in = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_acc_valid", 32'(acc_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", inpdt_R_reg, 32'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // Test 1: zero-point bytes, latency from start
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        run_beats(0, 1'b0, 1'b0, NB, 1'b1, cyc);
        chk("t1_latency", 32'(cyc + 1), 32'(NB + 1));
        chk("t1_valid_now", 32'(acc_valid), 32'd1);
        chk("t1_const", inpdt_R_reg, 32'h0);
        finish_result(0, 1'b0);

        // Test 2: in_valid in IDLE must not contribute
        set_pattern(2);
        in_valid = 1'b1;
        tick(); tick(); tick();
        chk("idle_ignores_beats", 32'(busy), 32'd0);
        in_valid = 1'b0;
        do_start();
        run_beats(1, 1'b0, 1'b0, NB, 1'b1, cyc);
        chk("t2_const", inpdt_R_reg, 32'h0020_0000);
        finish_result(0, 1'b0);

        // Test 3: negative products
        do_start();
        run_beats(2, 1'b0, 1'b0, NB, 1'b1, cyc);
        chk("t3_const", inpdt_R_reg, 32'hFFE0_4000);
        finish_result(0, 1'b0);

        // Test 4: stalled beats and delayed acc_ready
        do_start();
        run_beats(1, 1'b1, 1'b0, NB, 1'b1, cyc);
        finish_result(5, 1'b0);

        // Random lane data
        do_start();
        run_beats(3, 1'b0, 1'b0, NB, 1'b1, cyc);
        finish_result(2, 1'b0);

        // Test 5: async reset mid-product, then a clean product
        do_start();
        run_beats(3, 1'b0, 1'b0, 10, 1'b0, cyc);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t5_rst_valid", 32'(acc_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_result", inpdt_R_reg, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        do_start();
        run_beats(1, 1'b0, 1'b0, NB, 1'b1, cyc);
        chk("t5_const", inpdt_R_reg, 32'h0020_0000);
        finish_result(0, 1'b0);

        // Test 6: start during ACC, during DONE and in the handshake cycle
        do_start();
        run_beats(3, 1'b0, 1'b1, NB, 1'b1, cyc);
        chk("t6_beats_cycles", 32'(cyc), 32'(NB));
        finish_result(4, 1'b1);
        tick(); tick();
        chk("t6_single_busy", 32'(busy), 32'd0);
        chk("t6_single_valid", 32'(acc_valid), 32'd0);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
